// File: rtl/cms_trace_fifo.sv
// rtl/cms_trace_fifo.sv - trace packet FIFO between the monitor stream and the DMA stream
//
// First-word-fall-through FIFO for the monitor's trace packets. Each entry stores
// {tlast, tdata}. It reports the current fill level and a high-water mark.
//
// Optional feature macro: CMS_TRACE_FIFO_DROP_ON_FULL_EN
//   With the macro, the input never stalls. Packets offered while the FIFO is full,
//   or during a flush, are counted in drop_count. The next stored packet is then
//   marked with tlast=1.
//   Without the macro, the input back-pressures through S_AXIS_tready and
//   drop_count is 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of contents (high_water and drop_count kept)
//   S_AXIS_t*             input stream from the monitor (tdata = {pc, instr})
//   M_AXIS_t*             output stream to the DMA/host port
//   level                 current entry count, 0..DEPTH
//   high_water            maximum level since reset
//   drop_count            discarded packets (optional feature only)

module cms_trace_fifo #(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                  S_AXIS_tlast,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                  M_AXIS_tlast,
  output logic [ADDR_W:0]       level,
  output logic [ADDR_W:0]       high_water,
  output logic [31:0]           drop_count
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] head;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     high_water_q, high_water_d;
  logic [ADDR_W:0]     level_d;
  logic                empty, full, push, pop, wr_tlast;

  // The extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // flush wins over an offered packet, so a packet offered during a flush is never stored.
  assign push = S_AXIS_tvalid & ~full & ~flush;
  assign pop  = M_AXIS_tvalid & M_AXIS_tready;

`ifdef CMS_TRACE_FIFO_DROP_ON_FULL_EN
  logic [31:0] drop_count_q, drop_count_d;
  logic        drop_pending_q, drop_pending_d;
  logic        drop;

  assign S_AXIS_tready = 1'b1;
  assign drop          = S_AXIS_tvalid & (full | flush);
  // The first stored packet after a gap closes the packet, so software sees a boundary.
  assign wr_tlast      = S_AXIS_tlast | drop_pending_q;
  assign drop_count    = drop_count_q;

  always_comb begin
    drop_count_d   = drop_count_q;
    drop_pending_d = drop_pending_q;
    if (drop) begin
      drop_pending_d = 1'b1;
      if (drop_count_q != 32'hFFFF_FFFF) begin
        drop_count_d = drop_count_q + 32'd1;
      end
    end else if (push) begin
      drop_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q   <= 32'd0;
      drop_pending_q <= 1'b0;
    end else begin
      drop_count_q   <= drop_count_d;
      drop_pending_q <= drop_pending_d;
    end
  end
`else
  // full is computed from registered pointers only. A pop never opens a slot in the same cycle.
  assign S_AXIS_tready = ~full;
  assign wr_tlast      = S_AXIS_tlast;
  assign drop_count    = 32'd0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    level_d      = wr_ptr_d - rd_ptr_d;
    // level never exceeds DEPTH, so high_water also saturates at DEPTH.
    high_water_d = (level_d > high_water_q) ? level_d : high_water_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      high_water_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      high_water_q <= high_water_d;
    end
  end

  // The storage array has no reset. Its contents are only visible through the gated head below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[ADDR_W-1:0]] <= {wr_tlast, S_AXIS_tdata};
  end

  assign head          = mem[rd_ptr_q[ADDR_W-1:0]];
  assign M_AXIS_tvalid = ~empty;
  // Zero the head while empty so the outputs have defined values out of reset.
  assign M_AXIS_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign M_AXIS_tlast  = empty ? 1'b0 : head[DATA_WIDTH];
  assign level         = wr_ptr_q - rd_ptr_q;
  assign high_water    = high_water_q;

endmodule
